// File: rtl/lzx_74hc161.sv
// lzx_74hc161: 4-bit synchronous binary counter with parallel load and cascade carry.
// Latency: load or count result is visible on Q one Clk edge after it is sampled; TC is purely combinational.
// Backpressure: none; the counter advances only when both CEP and CET are high, and cascades through TC into the next stage's CET.
//
// Ports:
//   Clk  - counter clock, rising-edge active
//   nRd  - asynchronous active-low master reset (direct clear of Q)
//   nLd  - active-low synchronous parallel load (wins over counting)
//   CEP  - count enable, parallel (shared by all cascaded stages)
//   CET  - count enable, trickle (fed from the previous stage's TC); also gates TC
//   D    - parallel load data, D[0] is the LSB
//   Q    - counter state, Q[0] is the LSB
//   TC   - terminal count: CET AND (Q == 15)
module lzx_74hc161 (
  input  logic       Clk,
  input  logic       nRd,
  input  logic       nLd,
  input  logic       CEP,
  input  logic       CET,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       TC
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Edge action priority: load, then count (both enables), otherwise hold.
  // Counting is modulo 16; the 4-bit add wraps 15 -> 0 on its own.
  always_comb begin
    q_d = q_q;
    if (!nLd) begin
      q_d = D;
    end else if (CEP && CET) begin
      q_d = q_q + 4'd1;
    end
  end

  // nRd clears asynchronously and, while held low, masks every Clk edge,
  // so an in-flight load or count is simply discarded.
  always_ff @(posedge Clk or negedge nRd) begin
    if (!nRd) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

  // Combinational carry: follows Q and CET with no clock latency. During
  // reset Q is 0, which forces TC low without an explicit reset term.
  assign TC = CET & (q_q == 4'hF);

endmodule

// File: tb/tb_lzx_74hc161.sv
module tb_lzx_74hc161;

  logic       clk;
  logic       nrd, nld, cep, cet;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;

  // cascade pair
  logic       c_nrd, c_nld, c_cep, c_cet;
  logic [3:0] c_dlo, c_dhi;
  logic [3:0] c_qlo, c_qhi;
  logic       c_tclo, c_tchi;

  int total = 0;
  int bad   = 0;

  lzx_74hc161 dut (
    .Clk(clk), .nRd(nrd), .nLd(nld), .CEP(cep), .CET(cet), .D(d), .Q(q), .TC(tc)
  );

  lzx_74hc161 u_lo (
    .Clk(clk), .nRd(c_nrd), .nLd(c_nld), .CEP(c_cep), .CET(c_cet), .D(c_dlo),
    .Q(c_qlo), .TC(c_tclo)
  );

  lzx_74hc161 u_hi (
    .Clk(clk), .nRd(c_nrd), .nLd(c_nld), .CEP(c_cep), .CET(c_tclo), .D(c_dhi),
    .Q(c_qhi), .TC(c_tchi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;   // rising edges at 5, 15, 25, ...

  // Advance one rising edge and land 1 ns after it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrd = 1'b0;
    #2;
    nrd = 1'b1;
    edge1();
  endtask

  task automatic test_reset();
    nld = 1'b0; cep = 1'b1; cet = 1'b1; d = 4'd5;
    nrd = 1'b0;
    #1;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_q: got %0d want 0", q); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %0b want 0", tc); end
    // edges with load and count requested while held in reset
    for (int i = 0; i < 3; i++) begin
      edge1();
      total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_edge_ignored[%0d]: got %0d want 0", i, q); end
    end
    // release mid-cycle, count up to 9
    nrd = 1'b1; nld = 1'b1;
    for (int i = 1; i <= 9; i++) edge1();
    total++; if (q !== 4'd9) begin bad++; $display("FAIL count_to_9: got %0d want 9", q); end
    // pulse reset between edges: Q clears at once
    #2;
    nrd = 1'b0;
    #1;
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_async: got %0d want 0", q); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_async_tc: got %0b want 0", tc); end
    nld = 1'b0; d = 4'hF;
    edge1();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL reset_load_ignored: got %0d want 0", q); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_hold_tc: got %0b want 0", tc); end
    nld = 1'b1;
    nrd = 1'b1;
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp;
    nld = 1'b1; cep = 1'b0; cet = 1'b1;
    do_reset();
    cep = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      edge1();
      exp = 4'(i % 16);
      total++; if (q !== exp) begin bad++; $display("FAIL wrap_q[%0d]: got %0d want %0d", i, q, exp); end
      total++; if (tc !== (exp == 4'd15)) begin bad++; $display("FAIL wrap_tc[%0d]: got %0b want %0b", i, tc, (exp == 4'd15)); end
    end
  endtask

  task automatic test_load_priority();
    nld = 1'b0; d = 4'd5; cep = 1'b1; cet = 1'b1;
    edge1();
    total++; if (q !== 4'd5) begin bad++; $display("FAIL load_5: got %0d want 5", q); end
    d = 4'b1100; cep = 1'b0; cet = 1'b0;
    edge1();
    total++; if (q !== 4'd12) begin bad++; $display("FAIL load_12: got %0d want 12", q); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL load_12_tc: got %0b want 0", tc); end
    d = 4'd15; cet = 1'b1;
    edge1();
    total++; if (q !== 4'd15) begin bad++; $display("FAIL load_15: got %0d want 15", q); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL load_15_tc: got %0b want 1", tc); end
    // load with both enables high still loads rather than counts
    d = 4'd7; cep = 1'b1;
    edge1();
    total++; if (q !== 4'd7) begin bad++; $display("FAIL load_over_count: got %0d want 7", q); end
    nld = 1'b1;
  endtask

  task automatic test_enables();
    nld = 1'b0; d = 4'd3;
    edge1();
    nld = 1'b1; cep = 1'b0; cet = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge1();
      total++; if (q !== 4'd3) begin bad++; $display("FAIL hold_cep0[%0d]: got %0d want 3", i, q); end
    end
    cep = 1'b1; cet = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge1();
      total++; if (q !== 4'd3) begin bad++; $display("FAIL hold_cet0[%0d]: got %0d want 3", i, q); end
    end
    // glitches on inputs between edges must not reach Q
    #1; nld = 1'b0; d = 4'd9; #1; nld = 1'b1; cep = 1'b1; cet = 1'b1; #1; cet = 1'b0; d = 4'd3;
    total++; if (q !== 4'd3) begin bad++; $display("FAIL glitch_q: got %0d want 3", q); end
    // TC tracks CET combinationally at Q=15
    edge1();
    nld = 1'b0; d = 4'd15; cep = 1'b0; cet = 1'b0;
    edge1();
    nld = 1'b1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL tc_cet0: got %0b want 1'b0", tc); end
    #1; cet = 1'b1; #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL tc_cet1: got %0b want 1", tc); end
    cet = 1'b0; #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL tc_cet_back0: got %0b want 0", tc); end
    total++; if (q !== 4'd15) begin bad++; $display("FAIL tc_toggle_q: got %0d want 15", q); end
  endtask

  task automatic test_cascade();
    logic [7:0] exp [3];
    exp[0] = 8'h0F; exp[1] = 8'h10; exp[2] = 8'h11;
    c_nrd = 1'b0; c_nld = 1'b1; c_cep = 1'b0; c_cet = 1'b1; c_dlo = 4'hE; c_dhi = 4'h0;
    #2;
    c_nrd = 1'b1;
    c_nld = 1'b0;
    edge1();
    total++; if ({c_qhi, c_qlo} !== 8'h0E) begin bad++; $display("FAIL cascade_load: got %h want 0e", {c_qhi, c_qlo}); end
    total++; if (c_tclo !== 1'b0) begin bad++; $display("FAIL cascade_tc_0e: got %0b want 0", c_tclo); end
    c_nld = 1'b0; c_nld = 1'b1; c_cep = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      total++; if ({c_qhi, c_qlo} !== exp[i]) begin bad++; $display("FAIL cascade_q[%0d]: got %h want %h", i, {c_qhi, c_qlo}, exp[i]); end
      total++; if (c_tclo !== (exp[i][3:0] == 4'hF)) begin bad++; $display("FAIL cascade_tc[%0d]: got %0b want %0b", i, c_tclo, (exp[i][3:0] == 4'hF)); end
    end
    c_cep = 1'b0;
  endtask

  task automatic test_reset_release();
    nld = 1'b1; cep = 1'b1; cet = 1'b1;
    nrd = 1'b0;
    edge1();
    total++; if (q !== 4'd0) begin bad++; $display("FAIL release_low_edge: got %0d want 0", q); end
    #7;            // 2 ns before the next rising edge
    nrd = 1'b1;
    edge1();
    total++; if (q !== 4'd1) begin bad++; $display("FAIL release_first_count: got %0d want 1", q); end
    edge1();
    total++; if (q !== 4'd2) begin bad++; $display("FAIL release_second_count: got %0d want 2", q); end
  endtask

  initial begin
    nrd = 1'b0; nld = 1'b1; cep = 1'b0; cet = 1'b0; d = 4'd0;
    c_nrd = 1'b0; c_nld = 1'b1; c_cep = 1'b0; c_cet = 1'b0; c_dlo = 4'd0; c_dhi = 4'd0;
    #3;
    test_reset();
    test_count_wrap();
    test_load_priority();
    test_enables();
    test_cascade();
    test_reset_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within 20000 ns");
    $fatal(1);
  end

endmodule
